// File: rtl/gf_mul_alpha.sv
// gf_mul_alpha: registered constant multiplier in GF(2^m).
// out_1 = in_1 * alpha^PARAM_ALPHA, polynomial basis, alpha a root of the
// fixed primitive polynomial for PARAM_M. The constant is folded into an
// m x m XOR matrix at elaboration, so the datapath is one XOR layer plus
// a single output register.
module gf_mul_alpha #(
    parameter int PARAM_M     = 4,
    parameter int PARAM_ALPHA = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PARAM_M-1:0] in_1,
    output logic [PARAM_M-1:0] out_1
);

    // Multiplicative order of alpha; the exponent only matters modulo this.
    localparam int ORDER = (1 << PARAM_M) - 1;
    localparam int E_RED = PARAM_ALPHA % ORDER;

    // Primitive polynomial per field degree, including the x^m term.
    function automatic logic [16:0] poly_for(input int m);
        case (m)
            3:       return 17'h0000B;
            4:       return 17'h00013;
            5:       return 17'h00025;
            6:       return 17'h00043;
            7:       return 17'h00083;
            8:       return 17'h0011D;
            9:       return 17'h00211;
            10:      return 17'h00409;
            11:      return 17'h00805;
            12:      return 17'h01053;
            13:      return 17'h0201B;
            14:      return 17'h04443;
            15:      return 17'h08003;
            16:      return 17'h1100B;
            default: return 17'h00000;
        endcase
    endfunction

    localparam logic [16:0]        POLY_FULL = poly_for(PARAM_M);
    localparam logic [PARAM_M-1:0] POLY_LOW  = POLY_FULL[PARAM_M-1:0];

    // Unsupported field degrees have no polynomial; stop elaboration.
    if (PARAM_M < 3 || PARAM_M > 16) begin : g_bad_m
        $error("gf_mul_alpha: PARAM_M must be in 3..16");
    end
    if (PARAM_ALPHA < 0) begin : g_bad_alpha
        $error("gf_mul_alpha: PARAM_ALPHA must be >= 0");
    end

    // One multiply-by-x step with reduction by p(x).
    function automatic logic [PARAM_M-1:0] mul_x(input logic [PARAM_M-1:0] v);
        logic [PARAM_M-1:0] shifted;
        shifted = {v[PARAM_M-2:0], 1'b0};
        return v[PARAM_M-1] ? (shifted ^ POLY_LOW) : shifted;
    endfunction

    // General field multiply, shift-and-add (Horner over the bits of b).
    function automatic logic [PARAM_M-1:0] gf_mul(input logic [PARAM_M-1:0] a,
                                                  input logic [PARAM_M-1:0] b);
        logic [PARAM_M-1:0] acc;
        acc = '0;
        for (int i = PARAM_M - 1; i >= 0; i--) begin
            acc = mul_x(acc);
            if (b[i]) acc = acc ^ a;
        end
        return acc;
    endfunction

    // alpha^e by square-and-multiply; alpha is the element x (2'b10).
    function automatic logic [PARAM_M-1:0] alpha_pow(input logic [15:0] e);
        logic [PARAM_M-1:0] result;
        logic [PARAM_M-1:0] base;
        result = PARAM_M'(1);
        base   = PARAM_M'(2);
        for (int i = 0; i < 16; i++) begin
            if (e[i]) result = gf_mul(result, base);
            base = gf_mul(base, base);
        end
        return result;
    endfunction

    localparam logic [PARAM_M-1:0] ALPHA_E = alpha_pow(16'(E_RED));

    // Column j of the constant matrix is alpha^e * x^j; gate it by in_1[j].
    logic [PARAM_M-1:0] col_terms [PARAM_M];

    for (genvar j = 0; j < PARAM_M; j++) begin : g_col
        localparam logic [PARAM_M-1:0] COL = gf_mul(ALPHA_E, PARAM_M'(1) << j);
        assign col_terms[j] = in_1[j] ? COL : '0;
    end

    logic [PARAM_M-1:0] product_d;
    logic [PARAM_M-1:0] out_q;

    // XOR-reduce the selected matrix columns into the product.
    always_comb begin
        // NOTE: default first so every path assigns product_d and no latch is inferred.
        product_d = '0;
        for (int j = 0; j < PARAM_M; j++) begin
            product_d = product_d ^ col_terms[j];
        end
    end

    // Output register: synchronous clear has priority over new data.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for sequential state avoids simulation races.
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= product_d;
        end
    end

    assign out_1 = out_q;

endmodule

// File: tb/tb_gf_mul_alpha.sv
// Directed bench for gf_mul_alpha: several m=4 exponents plus m=8, e=1.
// Expected values are hand-computed from the primitive polynomials
// (m=4: x^4+x+1, m=8: 0x11D); a short shift/XOR model covers a few
// random m=8 vectors.
module tb_gf_mul_alpha;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in4;
    logic [7:0] in8;

    logic [3:0] o4_e0, o4_e1, o4_e3, o4_e15, o4_e16;
    logic [7:0] o8_e1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf_mul_alpha #(.PARAM_M(4), .PARAM_ALPHA(0))  u_m4_e0  (.clk(clk), .rst(rst), .in_1(in4), .out_1(o4_e0));
    gf_mul_alpha #(.PARAM_M(4), .PARAM_ALPHA(1))  u_m4_e1  (.clk(clk), .rst(rst), .in_1(in4), .out_1(o4_e1));
    gf_mul_alpha #(.PARAM_M(4), .PARAM_ALPHA(3))  u_m4_e3  (.clk(clk), .rst(rst), .in_1(in4), .out_1(o4_e3));
    gf_mul_alpha #(.PARAM_M(4), .PARAM_ALPHA(15)) u_m4_e15 (.clk(clk), .rst(rst), .in_1(in4), .out_1(o4_e15));
    gf_mul_alpha #(.PARAM_M(4), .PARAM_ALPHA(16)) u_m4_e16 (.clk(clk), .rst(rst), .in_1(in4), .out_1(o4_e16));
    gf_mul_alpha #(.PARAM_M(8), .PARAM_ALPHA(1))  u_m8_e1  (.clk(clk), .rst(rst), .in_1(in8), .out_1(o8_e1));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference multiply-by-alpha for m=8, p(x)=0x11D.
    function automatic logic [7:0] model8(input logic [7:0] v);
        logic [7:0] s;
        s = v << 1;
        return v[7] ? (s ^ 8'h1D) : s;
    endfunction

    // m=4 directed vectors and hand-computed images.
    logic [3:0] v4     [4] = '{4'b1000, 4'b1111, 4'b1011, 4'b0000};
    logic [3:0] exp4_e1[4] = '{4'b0011, 4'b1101, 4'b0101, 4'b0000};
    logic [3:0] exp4_e3[4] = '{4'b1100, 4'b0001, 4'b0111, 4'b0000};

    // m=8 directed vectors and hand-computed images.
    logic [7:0] v8     [7] = '{8'h80, 8'h01, 8'hFF, 8'h53, 8'hCA, 8'h1D, 8'h00};
    logic [7:0] exp8_e1[7] = '{8'h1D, 8'h02, 8'hE3, 8'hA6, 8'h89, 8'h3A, 8'h00};

    initial begin
        logic [7:0] r;

        rst = 1'b1;
        in4 = 4'b0001;
        in8 = 8'h01;

        // Held in reset for two edges: every output is cleared.
        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_e0",  16'(o4_e0),  16'h0);
            check("rst_e1",  16'(o4_e1),  16'h0);
            check("rst_e3",  16'(o4_e3),  16'h0);
            check("rst_e15", 16'(o4_e15), 16'h0);
            check("rst_e16", 16'(o4_e16), 16'h0);
            check("rst_m8",  16'(o8_e1),  16'h0);
        end

        // First edge after release: in_1 = 0001.
        rst = 1'b0;
        step();
        check("rel_e1",  16'(o4_e1),  16'h2);
        check("rel_e3",  16'(o4_e3),  16'h8);
        check("rel_e0",  16'(o4_e0),  16'h1);
        check("rel_e15", 16'(o4_e15), 16'h1);
        check("rel_e16", 16'(o4_e16), 16'h2);
        check("rel_m8",  16'(o8_e1),  16'h02);

        // Back-to-back m=4 vectors, one per cycle.
        for (int k = 0; k < 4; k++) begin
            in4 = v4[k];
            step();
            check($sformatf("m4_e1_%0d", k),  16'(o4_e1),  16'(exp4_e1[k]));
            check($sformatf("m4_e3_%0d", k),  16'(o4_e3),  16'(exp4_e3[k]));
            check($sformatf("m4_e16_%0d", k), 16'(o4_e16), 16'(exp4_e1[k]));
            check($sformatf("m4_e15_%0d", k), 16'(o4_e15), 16'(v4[k]));
            check($sformatf("m4_e0_%0d", k),  16'(o4_e0),  16'(v4[k]));
        end

        // Output is registered: a new input does not show before the edge.
        in4 = 4'b1000;
        #1;
        check("hold_e1", 16'(o4_e1), 16'h0);
        step();
        check("lat_e1", 16'(o4_e1), 16'h3);

        // Reset mid-stream clears, then the next edge computes normally.
        in4 = 4'b1111;
        rst = 1'b1;
        step();
        check("mid_rst_e1", 16'(o4_e1), 16'h0);
        check("mid_rst_e3", 16'(o4_e3), 16'h0);
        rst = 1'b0;
        step();
        check("post_rst_e1", 16'(o4_e1), 16'hD);
        check("post_rst_e3", 16'(o4_e3), 16'h1);

        // Back-to-back m=8 directed vectors.
        for (int k = 0; k < 7; k++) begin
            in8 = v8[k];
            step();
            check($sformatf("m8_dir_%0d", k), 16'(o8_e1), 16'(exp8_e1[k]));
        end

        // Back-to-back random m=8 vectors against the shift/XOR model.
        for (int k = 0; k < 8; k++) begin
            r = 8'($urandom_range(255, 0));
            in8 = r;
            step();
            check($sformatf("m8_rnd_%0d", k), 16'(o8_e1), 16'(model8(r)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
